// File: rtl/piggy_report_rx.sv
// 8N1 UART receiver plus parser for the 13-byte piggy-bank report frame.
// It turns "DDDDDDDDDDDD\n" into four binary coin counts and publishes all four together.
module piggy_report_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_amount0,
    output logic [7:0] o_amount1,
    output logic [7:0] o_amount2,
    output logic [7:0] o_amount3,
    output logic       o_frame_valid,
    output logic       o_frame_err,
    output logic       o_rx_busy
);
    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF   = TW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0]    ASCII_LF = 8'h0A;
    localparam logic [7:0]    ASCII_0  = 8'h30;
    localparam logic [7:0]    ASCII_9  = 8'h39;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
    typedef enum logic {P_DIGIT, P_RESYNC} parse_state_e;

    logic            sync1_q, sync1_d, rx_s_q, rx_s_d;
    bit_state_e      bit_state_q, bit_state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_stb_q, byte_stb_d;
    logic            stop_err_q, stop_err_d;
    logic            busy_q, busy_d;
    parse_state_e    parse_q, parse_d;
    logic [3:0]      idx_q, idx_d;
    logic [9:0]      acc_q, acc_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [3:0][7:0] amount_q, amount_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic       is_digit, field_end, raise_err;
    logic [1:0] field;
    logic [9:0] acc_next;

    // Bit-level receiver: start-bit centring, then one sample per bit period.
    always_comb begin
        sync1_d     = i_Rx_Serial;
        rx_s_d      = sync1_q;
        bit_state_d = bit_state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_stb_d  = 1'b0;
        stop_err_d  = 1'b0;
        busy_d      = busy_q;
        case (bit_state_q)
            B_IDLE: begin
                if (!rx_s_q) begin
                    bit_state_d = B_START;
                    timer_d     = '0;
                    busy_d      = 1'b1;
                end
            end
            B_START: begin
                if (timer_q == T_HALF) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    if (rx_s_q) begin
                        bit_state_d = B_IDLE;
                        busy_d      = 1'b0;
                    end else begin
                        bit_state_d = B_DATA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            B_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) bit_state_d = B_STOP;
                    else                   bit_idx_d   = bit_idx_q + 3'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (timer_q == T_LAST) begin
                    timer_d     = '0;
                    bit_state_d = B_IDLE;
                    busy_d      = 1'b0;
                    byte_stb_d  = 1'b1;
                    stop_err_d  = !rx_s_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
        endcase
    end

    assign is_digit  = (shift_q >= ASCII_0) && (shift_q <= ASCII_9);
    assign field     = 2'(idx_q / 4'd3);
    assign field_end = (idx_q == 4'd2) || (idx_q == 4'd5) || (idx_q == 4'd8) || (idx_q == 4'd11);
    assign acc_next  = 10'(acc_q * 10'd10) + {6'd0, shift_q[3:0]};

    // Frame parser: acts only on the registered byte strobe.
    always_comb begin
        parse_d   = parse_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        amount_d  = amount_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        raise_err = 1'b0;
        if (byte_stb_q) begin
            if (parse_q == P_RESYNC) begin
                if (!stop_err_q && shift_q == ASCII_LF) begin
                    parse_d = P_DIGIT;
                    idx_d   = 4'd0;
                    acc_d   = '0;
                end
            end else if (stop_err_q) begin
                raise_err = 1'b1;
            end else if (idx_q == 4'd12) begin
                if (shift_q == ASCII_LF) begin
                    amount_d = shadow_q;
                    valid_d  = 1'b1;
                    idx_d    = 4'd0;
                end else begin
                    raise_err = 1'b1;
                end
            end else if (is_digit) begin
                if (!field_end) begin
                    acc_d = acc_next;
                    idx_d = idx_q + 4'd1;
                end else if (acc_next > 10'd255) begin
                    raise_err = 1'b1;
                end else begin
                    shadow_d[field] = acc_next[7:0];
                    acc_d           = '0;
                    idx_d           = idx_q + 4'd1;
                end
            end else if (!(shift_q == ASCII_LF && idx_q == 4'd0)) begin
                raise_err = 1'b1;
            end
        end
        if (raise_err) begin
            err_d   = 1'b1;
            parse_d = P_RESYNC;
            idx_d   = 4'd0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            bit_state_q <= B_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_stb_q  <= 1'b0;
            stop_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            parse_q     <= P_DIGIT;
            idx_q       <= 4'd0;
            acc_q       <= '0;
            shadow_q    <= '0;
            amount_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            bit_state_q <= bit_state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_stb_q  <= byte_stb_d;
            stop_err_q  <= stop_err_d;
            busy_q      <= busy_d;
            parse_q     <= parse_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            shadow_q    <= shadow_d;
            amount_q    <= amount_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_amount0     = amount_q[0];
    assign o_amount1     = amount_q[1];
    assign o_amount2     = amount_q[2];
    assign o_amount3     = amount_q[3];
    assign o_frame_valid = valid_q;
    assign o_frame_err   = err_q;
    assign o_rx_busy     = busy_q;
endmodule

// File: tb/tb_piggy_report_rx.sv
// Bench for piggy_report_rx: serial driver, string-level frame model feeding an
// expected-event queue, and a pulse monitor that pops and compares each event.
module tb_piggy_report_rx;
    localparam int CPB  = 32;
    localparam int HALF = (CPB - 1) / 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] o_amount0, o_amount1, o_amount2, o_amount3;
    logic       o_frame_valid, o_frame_err, o_rx_busy;
    logic [31:0] amounts;

    int checks = 0;
    int errors = 0;

    // Each entry: {is_err, amount0, amount1, amount2, amount3} seen at the pulse.
    logic [32:0] exp_q[$];

    bit         m_resync = 1'b0;
    logic [7:0] m_buf[$];
    int         m_amt[4] = '{0, 0, 0, 0};

    piggy_report_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_Rx_Serial  (rx_line),
        .o_amount0    (o_amount0),
        .o_amount1    (o_amount1),
        .o_amount2    (o_amount2),
        .o_amount3    (o_amount3),
        .o_frame_valid(o_frame_valid),
        .o_frame_err  (o_frame_err),
        .o_rx_busy    (o_rx_busy)
    );

    assign amounts = {o_amount0, o_amount1, o_amount2, o_amount3};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (frame text rules) ----------------
    function automatic logic [31:0] amt_word();
        return {m_amt[0][7:0], m_amt[1][7:0], m_amt[2][7:0], m_amt[3][7:0]};
    endfunction

    function automatic int field_val(input int f);
        return (int'(m_buf[3*f]) - 48) * 100 + (int'(m_buf[3*f+1]) - 48) * 10
               + (int'(m_buf[3*f+2]) - 48);
    endfunction

    task automatic model_err();
        exp_q.push_back({1'b1, amt_word()});
        m_resync = 1'b1;
        m_buf.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (m_resync) begin
            if (stop_ok && b == 8'h0A) begin
                m_resync = 1'b0;
                m_buf.delete();
            end
        end else if (!stop_ok) begin
            model_err();
        end else if (m_buf.size() == 12) begin
            if (b == 8'h0A) begin
                for (int f = 0; f < 4; f++) m_amt[f] = field_val(f);
                exp_q.push_back({1'b0, amt_word()});
                m_buf.delete();
            end else begin
                model_err();
            end
        end else if (b == 8'h0A && m_buf.size() == 0) begin
            // blank line: nothing happens
        end else if (b < 8'h30 || b > 8'h39) begin
            model_err();
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() % 3 == 0 && field_val(m_buf.size() / 3 - 1) > 255) model_err();
        end
    endtask

    task automatic model_reset();
        m_resync = 1'b0;
        m_buf.delete();
        for (int f = 0; f < 4; f++) m_amt[f] = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) idle(12 * CPB);
        idle(int'($urandom_range(0, 6)));
    endtask

    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic send_random_frame(input bit allow_bad);
        logic [7:0] fr[13];
        int v;
        for (int f = 0; f < 4; f++) begin
            v = int'($urandom_range(0, allow_bad ? 299 : 255));
            fr[3*f]   = 8'(48 + v / 100);
            fr[3*f+1] = 8'(48 + (v / 10) % 10);
            fr[3*f+2] = 8'(48 + v % 10);
        end
        fr[12] = 8'h0A;
        if (allow_bad && $urandom_range(0, 2) == 0)
            fr[$urandom_range(0, 12)] = 8'($urandom_range(8'h3A, 8'h7E));
        for (int i = 0; i < 13; i++) send_byte(fr[i], 1'b1);
    endtask

    task automatic settle(input string tag);
        idle(3 * CPB);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_amounts"}, 64'(amounts), 64'(amt_word()));
    endtask

    // ---------------- pulse monitor ----------------
    always @(negedge clk) begin : monitor
        logic [32:0] want;
        if (rst_n && (o_frame_valid || o_frame_err)) begin
            check("no_dual_pulse", 64'(o_frame_valid & o_frame_err), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'({o_frame_err, o_frame_valid}), 64'd0);
            end else begin
                want = exp_q.pop_front();
                check("frame_event", 64'({o_frame_err, amounts}), 64'(want));
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_amounts", 64'(amounts), 64'd0);
        check("reset_flags", 64'({o_frame_valid, o_frame_err, o_rx_busy}), 64'd0);
        rst_n = 1'b1;
        idle(2 * CPB);

        send_frame("010005002255\n");
        settle("t1");
        check("t1_values", 64'(amounts), 64'({8'd10, 8'd5, 8'd2, 8'd255}));

        send_frame("000000000000\n");
        send_frame("001002003004\n");
        settle("t2");
        check("t2_values", 64'(amounts), 64'({8'd1, 8'd2, 8'd3, 8'd4}));

        send_frame("0100050A2255\n");
        settle("t3a");
        check("t3_unchanged", 64'(amounts), 64'({8'd1, 8'd2, 8'd3, 8'd4}));
        send_frame("003000000000\n");
        settle("t3b");
        check("t3_values", 64'(amounts), 64'({8'd3, 8'd0, 8'd0, 8'd0}));

        send_frame("256000000000\n");
        settle("t4a");
        check("t4_unchanged", 64'(amounts), 64'({8'd3, 8'd0, 8'd0, 8'd0}));
        send_frame("123045067089\n");
        settle("t4b");
        check("t4_values", 64'(amounts), 64'({8'd123, 8'd45, 8'd67, 8'd89}));

        send_frame("1234");
        send_byte("5", 1'b0);
        send_byte(8'h0A, 1'b1);
        settle("t5a");
        send_random_frame(1'b0);
        settle("t5b");

        // Short low glitch on an idle line: START only, then back to idle.
        rx_line = 1'b0;
        repeat (10) @(negedge clk);
        rx_line = 1'b1;
        check("glitch_busy_in_start", 64'(o_rx_busy), 64'd1);
        repeat (HALF + 6) @(negedge clk);
        check("glitch_busy_released", 64'(o_rx_busy), 64'd0);
        settle("t6_glitch");

        send_frame("09876");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n   = 1'b0;
        rx_line = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("midreset_amounts", 64'(amounts), 64'd0);
        check("midreset_flags", 64'({o_frame_valid, o_frame_err, o_rx_busy}), 64'd0);
        rst_n = 1'b1;
        idle(2 * CPB);
        send_random_frame(1'b0);
        settle("t6_after_reset");

        for (int n = 0; n < 3; n++) begin
            send_random_frame(1'b1);
            settle("rand");
        end
        send_random_frame(1'b0);
        settle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
